// File: rtl/traffic_ctrl_param.sv
// -----------------------------------------------------------------------------
// traffic_ctrl_param
//
// Intersection controller for one car signal head and one pedestrian head.
// Car phases run GREEN -> YEL1 -> LEFT -> YEL2, then either the pedestrian
// phases WALK -> FLASH -> ALLRED (when a push-button request is pending) or
// straight to ALLRED, then back to GREEN. Phase lengths are given in ticks; a
// tick is produced by an internal prescaler every TICK_DIV clocks, so a phase
// of length T lasts exactly T*TICK_DIV clocks.
//
// Optional feature (macro TRAFFIC_NIGHT_FLASH_EN):
//   Adds input i_night. At the end of ALLRED with i_night=1 the controller
//   enters NIGHT: car head blinks yellow (T_YELLOW ticks on, T_YELLOW ticks
//   off), walker head dark, requests ignored. i_night=0 returns via a full
//   ALLRED to GREEN. NIGHT reports o_state=0, like IDLE.
//
// Ports:
//   clk               in   clock
//   reset_n           in   synchronous, active-low reset
//   i_start           in   run enable; low forces IDLE (dark) at the next edge
//   i_ped_req         in   pedestrian request, level or pulse
//   i_night           in   night-flash request (only with TRAFFIC_NIGHT_FLASH_EN)
//   o_car_traffic     out  one-hot {RED,YELLOW,LEFT,GREEN}; 0000 = dark
//   o_walker_traffic  out  one-hot {RED,GREEN}; 00 = dark
//   o_ped_ack         out  1-clk pulse on the first clk of WALK
//   o_state           out  FSM state encoding for debug
// -----------------------------------------------------------------------------
module traffic_ctrl_param #(
   parameter int TICK_DIV = 1,
   parameter int T_GREEN  = 21,
   parameter int T_YELLOW = 2,
   parameter int T_LEFT   = 10,
   parameter int T_WALK   = 14,
   parameter int T_FLASH  = 6,
   parameter int T_ALLRED = 14,
   parameter int CW       = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_start,
   input  logic       i_ped_req,
`ifdef TRAFFIC_NIGHT_FLASH_EN
   input  logic       i_night,
`endif
   output logic [3:0] o_car_traffic,
   output logic [1:0] o_walker_traffic,
   output logic       o_ped_ack,
   output logic [2:0] o_state
);

`ifdef TRAFFIC_NIGHT_FLASH_EN
   // NIGHT needs its own internal code; its low three bits read as 0 on o_state.
   localparam int SW = 4;
`else
   localparam int SW = 3;
`endif

   typedef enum logic [SW-1:0] {
      S_IDLE   = SW'(0),
      S_GREEN  = SW'(1),
      S_YEL1   = SW'(2),
      S_LEFT   = SW'(3),
      S_YEL2   = SW'(4),
      S_WALK   = SW'(5),
      S_FLASH  = SW'(6),
`ifdef TRAFFIC_NIGHT_FLASH_EN
      S_ALLRED = SW'(7),
      S_NIGHT  = SW'(8)
`else
      S_ALLRED = SW'(7)
`endif
   } state_t;

   state_t        state, nxt_state;
   logic [CW-1:0] presc, nxt_presc;
   logic [CW-1:0] timer, nxt_timer;
   logic          ped_pending, nxt_pending;
   logic [CW-1:0] phase_last;
   logic          tick, phase_end, req_ok;
   logic [3:0]    nxt_car;
   logic [1:0]    nxt_walker;
   logic          nxt_ack;
`ifdef TRAFFIC_NIGHT_FLASH_EN
   logic          blink_off, nxt_blink_off;
`endif

   always_comb begin
      // Last timer value of the current phase.
      case (state)
         S_GREEN:  phase_last = CW'(T_GREEN  - 1);
         S_YEL1:   phase_last = CW'(T_YELLOW - 1);
         S_LEFT:   phase_last = CW'(T_LEFT   - 1);
         S_YEL2:   phase_last = CW'(T_YELLOW - 1);
         S_WALK:   phase_last = CW'(T_WALK   - 1);
         S_FLASH:  phase_last = CW'(T_FLASH  - 1);
         S_ALLRED: phase_last = CW'(T_ALLRED - 1);
`ifdef TRAFFIC_NIGHT_FLASH_EN
         S_NIGHT:  phase_last = CW'(T_YELLOW - 1);
`endif
         default:  phase_last = '0;
      endcase

      tick      = (presc == CW'(TICK_DIV - 1));
      phase_end = tick && (timer == phase_last);

      // Requests latch everywhere except where they are meaningless.
      req_ok = (state != S_IDLE) && (state != S_WALK);
`ifdef TRAFFIC_NIGHT_FLASH_EN
      req_ok = req_ok && (state != S_NIGHT);
      nxt_blink_off = blink_off;
`endif

      // NOTE: every variable of this always_comb gets a default before any
      // branch so that no path leaves one unassigned (which would infer a latch).
      nxt_state   = state;
      nxt_presc   = tick ? '0 : presc + CW'(1);
      nxt_timer   = tick ? timer + CW'(1) : timer;
      nxt_pending = ped_pending | (i_ped_req & req_ok);

      case (state)
         S_IDLE:  nxt_state = S_GREEN;
         S_GREEN: if (phase_end) nxt_state = S_YEL1;
         S_YEL1:  if (phase_end) nxt_state = S_LEFT;
         S_LEFT:  if (phase_end) nxt_state = S_YEL2;
         S_YEL2: begin
            // Decision uses the registered flag; a request arriving on this
            // very clk is served together with it (clear wins).
            if (phase_end) begin
               if (ped_pending) begin
                  nxt_state   = S_WALK;
                  nxt_pending = 1'b0;
               end else begin
                  nxt_state = S_ALLRED;
               end
            end
         end
         S_WALK:  if (phase_end) nxt_state = S_FLASH;
         S_FLASH: if (phase_end) nxt_state = S_ALLRED;
`ifdef TRAFFIC_NIGHT_FLASH_EN
         S_ALLRED: if (phase_end) nxt_state = i_night ? S_NIGHT : S_GREEN;
         S_NIGHT: begin
            if (!i_night) begin
               nxt_state = S_ALLRED;
            end else if (phase_end) begin
               // Each half of the blink is one T_YELLOW-long stretch.
               nxt_timer     = '0;
               nxt_blink_off = ~blink_off;
            end
         end
`else
         S_ALLRED: if (phase_end) nxt_state = S_GREEN;
`endif
         default: nxt_state = S_IDLE;
      endcase

      // Every state entry restarts the prescaler and phase timer.
      if (nxt_state != state) begin
         nxt_presc = '0;
         nxt_timer = '0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
         nxt_blink_off = 1'b0;
`endif
      end

      if (!i_start) begin
         nxt_state   = S_IDLE;
         nxt_presc   = '0;
         nxt_timer   = '0;
         nxt_pending = 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
         nxt_blink_off = 1'b0;
`endif
      end

      // Output decode of the state being entered, so the registered outputs
      // line up with the registered state.
      nxt_car    = 4'b0000;
      nxt_walker = 2'b00;
      case (nxt_state)
         S_GREEN:  begin nxt_car = 4'b0001; nxt_walker = 2'b10; end
         S_YEL1:   begin nxt_car = 4'b0100; nxt_walker = 2'b10; end
         S_LEFT:   begin nxt_car = 4'b0010; nxt_walker = 2'b10; end
         S_YEL2:   begin nxt_car = 4'b0100; nxt_walker = 2'b10; end
         S_WALK:   begin nxt_car = 4'b1000; nxt_walker = 2'b01; end
         S_FLASH:  begin nxt_car = 4'b1000; nxt_walker = nxt_timer[0] ? 2'b00 : 2'b01; end
         S_ALLRED: begin nxt_car = 4'b1000; nxt_walker = 2'b10; end
`ifdef TRAFFIC_NIGHT_FLASH_EN
         S_NIGHT:  begin nxt_car = nxt_blink_off ? 4'b0000 : 4'b0100; end
`endif
         default:  begin nxt_car = 4'b0000; nxt_walker = 2'b00; end
      endcase

      nxt_ack = (nxt_state == S_WALK) && (state != S_WALK);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values computed above.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state            <= S_IDLE;
         presc            <= '0;
         timer            <= '0;
         ped_pending      <= 1'b0;
         o_car_traffic    <= 4'b0000;
         o_walker_traffic <= 2'b00;
         o_ped_ack        <= 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
         blink_off        <= 1'b0;
`endif
      end else begin
         state            <= nxt_state;
         presc            <= nxt_presc;
         timer            <= nxt_timer;
         ped_pending      <= nxt_pending;
         o_car_traffic    <= nxt_car;
         o_walker_traffic <= nxt_walker;
         o_ped_ack        <= nxt_ack;
`ifdef TRAFFIC_NIGHT_FLASH_EN
         blink_off        <= nxt_blink_off;
`endif
      end
   end

   assign o_state = state[2:0];

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// -----------------------------------------------------------------------------
// tb_traffic_ctrl_param
//
// Randomized bench for traffic_ctrl_param. The driver picks inputs on each
// falling edge, advances a phase/elapsed-clock reference model by one clock
// and queues the outputs expected after the next rising edge. A separate
// monitor pops and compares one entry after every rising edge.
// -----------------------------------------------------------------------------
module tb_traffic_ctrl_param;

   localparam int TD       = 2;
   localparam int T_GREEN  = 4;
   localparam int T_YELLOW = 2;
   localparam int T_LEFT   = 3;
   localparam int T_WALK   = 3;
   localparam int T_FLASH  = 4;
   localparam int T_ALLRED = 2;
   localparam int N_CYCLES = 4000;

   localparam int P_IDLE = 0, P_GREEN = 1, P_YEL1 = 2, P_LEFT = 3,
                  P_YEL2 = 4, P_WALK = 5, P_FLASH = 6, P_ALLRED = 7;

   typedef struct {
      logic [3:0] car;
      logic [1:0] walker;
      logic       ack;
      logic [2:0] st;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       i_start;
   logic       i_ped_req;
   logic       i_night;
   logic [3:0] o_car_traffic;
   logic [1:0] o_walker_traffic;
   logic       o_ped_ack;
   logic [2:0] o_state;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model state: current phase, clocks spent in it, latched request.
   int   m_ph   = P_IDLE;
   int   m_el   = 0;
   bit   m_pend = 1'b0;
   bit   m_ack  = 1'b0;

   always #5 clk = ~clk;

   traffic_ctrl_param #(
      .TICK_DIV (TD),
      .T_GREEN  (T_GREEN),
      .T_YELLOW (T_YELLOW),
      .T_LEFT   (T_LEFT),
      .T_WALK   (T_WALK),
      .T_FLASH  (T_FLASH),
      .T_ALLRED (T_ALLRED),
      .CW       (4)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .i_start          (i_start),
      .i_ped_req        (i_ped_req),
`ifdef TRAFFIC_NIGHT_FLASH_EN
      .i_night          (i_night),
`endif
      .o_car_traffic    (o_car_traffic),
      .o_walker_traffic (o_walker_traffic),
      .o_ped_ack        (o_ped_ack),
      .o_state          (o_state)
   );

   task automatic check(input string name, input int cyc,
                        input logic [9:0] got, input logic [9:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got car=%b walk=%b ack=%b st=%0d want car=%b walk=%b ack=%b st=%0d",
                  name, cyc, got[9:6], got[5:4], got[3], got[2:0],
                  want[9:6], want[5:4], want[3], want[2:0]);
      end
   endtask

   function automatic int phase_clks(input int ph);
      case (ph)
         P_GREEN:  return T_GREEN  * TD;
         P_YEL1:   return T_YELLOW * TD;
         P_LEFT:   return T_LEFT   * TD;
         P_YEL2:   return T_YELLOW * TD;
         P_WALK:   return T_WALK   * TD;
         P_FLASH:  return T_FLASH  * TD;
         P_ALLRED: return T_ALLRED * TD;
         default:  return 1;
      endcase
   endfunction

   // Advance the model across one rising edge with the given inputs.
   task automatic model_step(input bit rst_n, input bit start, input bit req);
      bit old_pend;
      m_ack = 1'b0;
      if (!rst_n || !start) begin
         m_ph   = P_IDLE;
         m_el   = 0;
         m_pend = 1'b0;
      end else if (m_ph == P_IDLE) begin
         m_ph = P_GREEN;
         m_el = 0;
      end else begin
         old_pend = m_pend;
         if (req && m_ph != P_WALK) m_pend = 1'b1;
         m_el++;
         if (m_el == phase_clks(m_ph)) begin
            m_el = 0;
            case (m_ph)
               P_GREEN:  m_ph = P_YEL1;
               P_YEL1:   m_ph = P_LEFT;
               P_LEFT:   m_ph = P_YEL2;
               P_YEL2: begin
                  if (old_pend) begin
                     m_ph   = P_WALK;
                     m_pend = 1'b0;
                     m_ack  = 1'b1;
                  end else begin
                     m_ph = P_ALLRED;
                  end
               end
               P_WALK:   m_ph = P_FLASH;
               P_FLASH:  m_ph = P_ALLRED;
               default:  m_ph = P_GREEN;
            endcase
         end
      end
   endtask

   function automatic exp_t model_outputs(input int cyc);
      exp_t e;
      e.cyc = cyc;
      e.ack = m_ack;
      e.st  = 3'(m_ph);
      case (m_ph)
         P_GREEN:  begin e.car = 4'b0001; e.walker = 2'b10; end
         P_YEL1:   begin e.car = 4'b0100; e.walker = 2'b10; end
         P_LEFT:   begin e.car = 4'b0010; e.walker = 2'b10; end
         P_YEL2:   begin e.car = 4'b0100; e.walker = 2'b10; end
         P_WALK:   begin e.car = 4'b1000; e.walker = 2'b01; end
         P_FLASH:  begin
            e.car    = 4'b1000;
            e.walker = ((m_el / TD) % 2 == 0) ? 2'b01 : 2'b00;
         end
         P_ALLRED: begin e.car = 4'b1000; e.walker = 2'b10; end
         default:  begin e.car = 4'b0000; e.walker = 2'b00; end
      endcase
      return e;
   endfunction

   // Driver: inputs change on the falling edge, expectations are queued.
   initial begin
      int start_low = 0;
      int req_hold  = 0;
      reset_n   = 1'b0;
      i_start   = 1'b0;
      i_ped_req = 1'b0;
      i_night   = 1'b0;
      for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
         @(negedge clk);
         // Reset for the first cycles and, rarely, mid-run.
         reset_n = !(cyc < 3 || $urandom_range(0, 999) == 0);
         // Run enable mostly high, with short random drop-outs.
         if (start_low > 0) begin
            start_low--;
            i_start = 1'b0;
         end else if (cyc < 5 || $urandom_range(0, 149) == 0) begin
            start_low = (cyc < 5) ? 0 : int'($urandom_range(0, 5));
            i_start   = 1'b0;
         end else begin
            i_start = 1'b1;
         end
         // Requests: single-clk pulses plus occasional long holds.
         if (req_hold > 0) begin
            req_hold--;
            i_ped_req = 1'b1;
         end else if ($urandom_range(0, 79) == 0) begin
            req_hold  = int'($urandom_range(10, 40));
            i_ped_req = 1'b1;
         end else begin
            i_ped_req = ($urandom_range(0, 29) == 0);
         end
         model_step(reset_n, i_start, i_ped_req);
         exp_q.push_back(model_outputs(cyc));
      end
      @(negedge clk);
      @(negedge clk);
      check("queue_drained", N_CYCLES, 10'(exp_q.size()), 10'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Monitor: compare one queued expectation after every rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs", e.cyc,
                  {o_car_traffic, o_walker_traffic, o_ped_ack, o_state},
                  {e.car, e.walker, e.ack, e.st});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
